// File: rtl/pit_timer_pkg.sv
// Shared constants for the programmable interval timer.
// Holds the datapath width and the register-write decode offsets.
package pit_timer_pkg;

  localparam int PIT_WIDTH = 16;

  localparam logic [3:0] PIT_PRE_OFS = 4'h0;
  localparam logic [3:0] PIT_DIV_OFS = 4'h4;

endpackage

// File: rtl/dncnt_word.sv
// Loadable down counter built as a ripple chain of per-bit cells.
// Ports: clk, resl, ld, ci, d in; q count, co = ci & (q == 0) out.
module dncnt_word
  import pit_timer_pkg::*;
#(
  parameter int WIDTH = PIT_WIDTH
) (
  input  logic             clk,
  input  logic             resl,
  input  logic             ld,
  input  logic             ci,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             co
);

  logic [WIDTH:0]   brw;
  logic [WIDTH-1:0] nxt;

  assign brw[0] = ci;

  // A borrow ripples up through every zero bit; the final
  // borrow doubles as the underflow carry of the word.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign brw[i+1] = brw[i] & ~q[i];
    assign nxt[i]   = ld ? d[i] : (q[i] ^ brw[i]);
  end

  assign co = brw[WIDTH];

  always_ff @(posedge clk) begin
    if (!resl) q <= '0;
    else       q <= nxt;
  end

endmodule

// File: rtl/pit_timer.sv
// Programmable interval timer: prescaler word feeding a divider word.
// Ports: pre_wr/pre_d, div_wr/div_d writes; pre_q, div_q, tick, pit_int.
module pit_timer
  import pit_timer_pkg::*;
#(
  parameter int WIDTH = PIT_WIDTH
) (
  input  logic             clk,
  input  logic             resl,
  input  logic             pre_wr,
  input  logic [WIDTH-1:0] pre_d,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] div_d,
  output logic [WIDTH-1:0] pre_q,
  output logic [WIDTH-1:0] div_q,
  output logic             tick,
  output logic             pit_int
);

  logic [WIDTH-1:0] pre_rl;
  logic [WIDTH-1:0] div_rl;
  logic [WIDTH-1:0] pre_ld_d;
  logic [WIDTH-1:0] div_ld_d;
  logic             run;
  logic             pre_co;
  logic             div_co;
  logic             pre_uf;
  logic             pre_ld;
  logic             div_ld;

  assign run = |pre_rl;

  // A write replaces the reload and masks that cycle's underflow.
  assign pre_ld   = pre_wr | pre_co;
  assign pre_ld_d = pre_wr ? pre_d : pre_rl;
  assign pre_uf   = pre_co & ~pre_wr;

  assign div_ld   = div_wr | div_co;
  assign div_ld_d = div_wr ? div_d : div_rl;

  dncnt_word #(.WIDTH(WIDTH)) u_pre (
    .clk  (clk),
    .resl (resl),
    .ld   (pre_ld),
    .ci   (run),
    .d    (pre_ld_d),
    .q    (pre_q),
    .co   (pre_co)
  );

  dncnt_word #(.WIDTH(WIDTH)) u_div (
    .clk  (clk),
    .resl (resl),
    .ld   (div_ld),
    .ci   (pre_uf),
    .d    (div_ld_d),
    .q    (div_q),
    .co   (div_co)
  );

  always_ff @(posedge clk) begin
    if (!resl) begin
      pre_rl  <= '0;
      div_rl  <= '0;
      tick    <= 1'b0;
      pit_int <= 1'b0;
    end else begin
      if (pre_wr) pre_rl <= pre_d;
      if (div_wr) div_rl <= div_d;
      tick    <= pre_uf;
      pit_int <= div_co & ~div_wr;
    end
  end

endmodule

// File: tb/tb_pit_timer.sv
// Scoreboard bench for pit_timer: directed writes queue expected
// pulses and state probes; a negedge monitor pops and compares.
module tb_pit_timer;

  logic        clk = 1'b0;
  logic        resl;
  logic        pre_wr;
  logic [15:0] pre_d;
  logic        div_wr;
  logic [15:0] div_d;
  logic [15:0] pre_q;
  logic [15:0] div_q;
  logic        tick;
  logic        pit_int;

  typedef struct {
    int          cyc;
    logic [15:0] pre;
    logic [15:0] dv;
    logic        t;
    logic        i;
  } exp_t;

  exp_t pulse_q[$];
  exp_t probe_q[$];

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  pit_timer #(.WIDTH(16)) dut (
    .clk     (clk),
    .resl    (resl),
    .pre_wr  (pre_wr),
    .pre_d   (pre_d),
    .div_wr  (div_wr),
    .div_d   (div_d),
    .pre_q   (pre_q),
    .div_q   (div_q),
    .tick    (tick),
    .pit_int (pit_int)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_pulse(input int c, input logic [15:0] p,
                            input logic [15:0] d, input logic t,
                            input logic i);
    exp_t e;
    e.cyc = c; e.pre = p; e.dv = d; e.t = t; e.i = i;
    pulse_q.push_back(e);
  endtask

  task automatic push_probe(input int c, input logic [15:0] p,
                            input logic [15:0] d, input logic t,
                            input logic i);
    exp_t e;
    e.cyc = c; e.pre = p; e.dv = d; e.t = t; e.i = i;
    probe_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic dp, input logic [15:0] pv,
                    input logic dd, input logic [15:0] dv,
                    output int e);
    pre_wr = dp; pre_d = pv;
    div_wr = dd; div_d = dv;
    @(posedge clk);
    #1;
    pre_wr = 1'b0;
    div_wr = 1'b0;
    e = cyc;
  endtask

  // Monitor: state probes at scheduled cycles, pulses on demand.
  always @(negedge clk) begin
    while (probe_q.size() > 0 && probe_q[0].cyc == cyc) begin
      exp_t e;
      e = probe_q.pop_front();
      n_chk++;
      if (pre_q === e.pre && div_q === e.dv &&
          tick === e.t && pit_int === e.i)
        n_pass++;
      else
        $display("FAIL probe@%0d got pre=%0d div=%0d t=%b i=%b want pre=%0d div=%0d t=%b i=%b",
                 cyc, pre_q, div_q, tick, pit_int, e.pre, e.dv, e.t, e.i);
    end
    if (tick === 1'b1 || pit_int === 1'b1) begin
      n_chk++;
      if (pulse_q.size() == 0) begin
        $display("FAIL unexpected_pulse@%0d t=%b i=%b want none",
                 cyc, tick, pit_int);
      end else begin
        exp_t e;
        e = pulse_q.pop_front();
        if (e.cyc == cyc && pre_q === e.pre && div_q === e.dv &&
            tick === e.t && pit_int === e.i)
          n_pass++;
        else
          $display("FAIL pulse got cyc=%0d pre=%0d div=%0d t=%b i=%b want cyc=%0d pre=%0d div=%0d t=%b i=%b",
                   cyc, pre_q, div_q, tick, pit_int,
                   e.cyc, e.pre, e.dv, e.t, e.i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int e, e2, f, g, h, r, s;
    resl = 1'b0; pre_wr = 1'b0; div_wr = 1'b0;
    pre_d = '0; div_d = '0;

    // reset then idle
    push_probe(2, 0, 0, 0, 0);
    push_probe(52, 0, 0, 0, 0);
    wait_cyc(2);
    resl = 1'b1;
    wait_cyc(52);

    // basic period: pre 3, div 2
    wr(1'b1, 16'd3, 1'b0, 16'd0, e);
    push_pulse(e + 4,  3, 1, 1, 0);
    push_pulse(e + 8,  3, 0, 1, 0);
    push_pulse(e + 12, 3, 2, 1, 1);
    push_pulse(e + 16, 3, 1, 1, 0);
    push_pulse(e + 20, 3, 0, 1, 0);
    push_pulse(e + 24, 3, 2, 1, 1);
    wr(1'b0, 16'd0, 1'b1, 16'd2, e2);
    wait_cyc(e + 24);

    // minimum divide: pre 1, div 0
    wr(1'b1, 16'd1, 1'b1, 16'd0, f);
    for (int k = 1; k <= 5; k++)
      push_pulse(f + 2 * k, 1, 0, 1, 1);
    wait_cyc(f + 11);

    // write collision on pre_q == 0
    wr(1'b1, 16'd5, 1'b0, 16'd0, g);
    push_probe(g, 5, 0, 0, 0);
    push_pulse(g + 6, 5, 0, 1, 1);
    wait_cyc(g + 8);

    // halt with divider preset, then restart
    wr(1'b1, 16'd0, 1'b1, 16'd7, h);
    push_probe(h, 0, 7, 0, 0);
    push_probe(h + 30, 0, 7, 0, 0);
    wait_cyc(h + 30);
    wr(1'b1, 16'd2, 1'b0, 16'd0, r);
    push_probe(r, 2, 7, 0, 0);
    for (int k = 1; k <= 6; k++)
      push_pulse(r + 3 * k, 2, 16'(7 - k), 1, 0);
    push_probe(r + 18, 2, 1, 1, 0);
    wait_cyc(r + 18);

    // reset mid-count with a colliding write
    resl = 1'b0; pre_wr = 1'b1; pre_d = 16'd9;
    @(posedge clk);
    #1;
    resl = 1'b1; pre_wr = 1'b0;
    s = cyc;
    push_probe(s, 0, 0, 0, 0);
    push_probe(s + 20, 0, 0, 0, 0);
    wait_cyc(s + 22);

    n_chk++;
    if (pulse_q.size() == 0) n_pass++;
    else $display("FAIL missing_pulses left=%0d want 0", pulse_q.size());
    n_chk++;
    if (probe_q.size() == 0) n_pass++;
    else $display("FAIL missing_probes left=%0d want 0", probe_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pit_timer.md
Name: pit_timer

Overview:
- Programmable interval timer built around the loadable down-counter bit-slice chain: a prescaler stage feeds a divider stage.
- The prescaler divides clk and emits a one-cycle tick. The divider counts ticks and emits a one-cycle interrupt request on underflow.
- Sits between the CPU register-write decode (upstream) and the interrupt controller (downstream).
- Both counters are readable for timer read-back.

Parameters:
- WIDTH, 16, width of the prescaler and divider reload registers and counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- resl  in  1  reset, synchronous, active-low; sampled on the clk rising edge.
- pre_wr  in  1  one-cycle strobe: write pre_d to the prescaler reload register and load it into the prescaler counter.
- pre_d  in  WIDTH  prescaler reload value.
- div_wr  in  1  one-cycle strobe: write div_d to the divider reload register and load it into the divider counter.
- div_d  in  WIDTH  divider reload value.
- pre_q  out  WIDTH  current prescaler count.
- div_q  out  WIDTH  current divider count.
- tick  out  1  registered one-cycle pulse on prescaler underflow.
- pit_int  out  1  registered one-cycle pulse on divider underflow.

Behaviour:
- Reset (resl=0 at a clk edge):
  - pre_rl, div_rl, pre_q and div_q clear to 0.
  - tick and pit_int clear to 0.
  - Reset overrides a simultaneous pre_wr or div_wr.
- Run condition: run = (pre_rl != 0). A zero prescaler reload halts the timer.
  - While halted, both counters hold and tick and pit_int stay 0.
  - div_rl = 0 is legal: it gives one pit_int per prescaler underflow.
- Prescaler, evaluated each cycle with run=1:
  - pre_q == 0: next pre_q = pre_rl; tick = 1 next cycle.
  - pre_q != 0: next pre_q = pre_q - 1; tick = 0 next cycle.
  - Underflow detection is the chain carry: co = ci & (all bits zero), with ci = run.
- Divider, evaluated on cycles where the prescaler underflows (the divider ci equals the prescaler co, not the registered tick):
  - div_q == 0: next div_q = div_rl; pit_int = 1 next cycle.
  - div_q != 0: next div_q = div_q - 1.
  - Cycles without a prescaler underflow: div_q holds.
- Period:
  - tick period = pre_rl + 1 cycles.
  - pit_int period = (pre_rl + 1) * (div_rl + 1) cycles, steady state.
- Writes:
  - pre_wr: pre_rl <= pre_d and pre_q <= pre_d on the same edge.
    - The load wins over decrement/reload, and the prescaler underflow for that cycle is suppressed: no tick, no divider step.
  - div_wr: div_rl <= div_d and div_q <= div_d on the same edge.
    - The load wins over a same-cycle divider step, and pit_int for that cycle is suppressed.
  - pre_wr and div_wr in the same cycle: both loads apply.
  - Writing pre_d = 0 halts the timer from the next cycle; the count reads 0.
  - Writing nonzero while halted restarts counting: the first tick occurs pre_d + 1 cycles after the write edge.
- Wrap: pure down-count with reload; no modular wrap past 0. The reload replaces the would-be all-ones value.
- Latency: tick and pit_int are asserted in the cycle after the edge on which the counter is observed at 0.
- Reset mid-count: all state returns to 0 and the timer halts until pre_wr writes a nonzero value.

Decomposition:
- Shared package holds:
  - PIT_WIDTH constant (16).
  - Register-offset constants for the prescaler and divider write decodes, used by the upstream decoder.
- One sub-module, dncnt_word:
  - WIDTH-bit loadable down counter formed as a ripple chain of per-bit down-count cells.
  - Inputs: d, ld, ci, resl, clk.
  - Outputs: q, co (co = ci & q==0).
  - Instantiated twice: prescaler and divider.
- The reload-on-underflow mux lives in pit_timer: ld = wr | co, with the load data chosen between d and the reload register.

Test Plan:
- Reset then idle: resl low 2 cycles, then high with no writes for 50 cycles -> pre_q = div_q = 0; tick and pit_int never assert.
- Basic period: write pre_d = 3, then div_d = 2 -> tick every 4 cycles; pit_int every 12 cycles, coincident with every third tick; div_q sequence 2, 1, 0, 2.
- Minimum divide: pre_d = 1, div_d = 0 -> tick and pit_int both pulse every 2 cycles, one cycle wide.
- Write collision: pre_wr with pre_d = 5 on the cycle pre_q = 0 -> no tick that cycle; pre_q = 5 next; next tick 6 cycles later; div_q unchanged.
- Halt and restart: pre_d = 0 mid-count -> counters freeze, no pulses for 30 cycles; then pre_d = 2 -> first tick 3 cycles after the write edge.
- Reset mid-operation: resl low while pre_q = 2 and div_q = 1, coincident with pre_wr -> all outputs 0 next cycle; write ignored; timer halted.
